// File: rtl/fxp2float_pipe.sv
// fxp2float_pipe: 3-stage valid/ready converter from signed/unsigned fixed point to IEEE-754 binary32
module fxp2float_pipe #(
  parameter int WOI = 1,
  parameter int WOF = 7,
  parameter int SIGNED = 1,
  localparam int W = WOI + WOF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_fxp,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_fp32
);
  logic v1, v2, v3, en1, en2, en3;
  logic s1_s, s1_z, s2_s, s2_z, in_s, rup;
  logic [W-1:0] s1_mag;
  logic [30:0] s2_frac;
  logic [7:0] s2_e, e3;
  logic [4:0] p;
  logic [23:0] rnd;
  assign en3 = ~v3 | out_ready;
  assign en2 = ~v2 | en3;
  assign en1 = ~v1 | en2;
  assign in_ready = en1;
  assign out_valid = v3;
  assign in_s = (SIGNED != 0) && in_fxp[W-1];
  always_comb begin
    p = '0;
    for (int i = 0; i < W; i++) if (s1_mag[i]) p = 5'(i);
  end
  // frac holds the bits below the leading one: [30:8] mantissa, [7] guard, [6:0] sticky
  assign rup = s2_frac[7] & ((|s2_frac[6:0]) | s2_frac[8]);
  assign rnd = {1'b0, s2_frac[30:8]} + 24'(rup);
  assign e3 = s2_e + 8'(rnd[23]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {v1, v2, v3} <= '0;
      {s1_s, s1_z, s2_s, s2_z} <= '0;
      s1_mag <= '0;
      s2_frac <= '0;
      s2_e <= '0;
      out_fp32 <= '0;
    end else begin
      if (en1) begin
        v1 <= in_valid;
        s1_s <= in_s;
        s1_mag <= in_s ? -in_fxp : in_fxp;
        s1_z <= in_fxp == '0;
      end
      if (en2) begin
        v2 <= v1;
        s2_s <= s1_s;
        s2_z <= s1_z;
        s2_frac <= 31'(32'(s1_mag) << (5'd31 - p));
        s2_e <= 8'(p) + 8'(127 - WOF);
      end
      if (en3) begin
        v3 <= v2;
        out_fp32 <= s2_z ? '0 : {s2_s, e3, rnd[22:0]};
      end
    end
  end
endmodule

// File: tb/tb_fxp2float_pipe.sv
// tb_fxp2float_pipe: directed and random checks of fxp2float_pipe in Q1.7 and 32-bit integer configurations
module tb_fxp2float_pipe;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic v8 = 0, or8 = 1, rdy8, ov8;
  logic [7:0] d8 = 0;
  logic [31:0] f8;
  logic v32 = 0, one = 1, rdy_u, rdy_s, ov_u, ov_s;
  logic [31:0] d32 = 0, f_u, f_s;
  int n = 0, err = 0;

  fxp2float_pipe u8 (.clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .in_fxp(d8),
    .out_valid(ov8), .out_ready(or8), .out_fp32(f8));
  fxp2float_pipe #(.WOI(32), .WOF(0), .SIGNED(0)) u32u (.clk(clk), .rst_n(rst_n), .in_valid(v32),
    .in_ready(rdy_u), .in_fxp(d32), .out_valid(ov_u), .out_ready(one), .out_fp32(f_u));
  fxp2float_pipe #(.WOI(32), .WOF(0), .SIGNED(1)) u32s (.clk(clk), .rst_n(rst_n), .in_valid(v32),
    .in_ready(rdy_s), .in_fxp(d32), .out_valid(ov_s), .out_ready(one), .out_fp32(f_s));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Q1.7 values are exact in double, so repack the double fields as single
  function automatic logic [31:0] ref8(input logic [7:0] x);
    logic [63:0] b;
    int e;
    if (x == 0) return 32'h0;
    b = $realtobits(real'(int'($signed(x))) / 128.0);
    e = int'(b[62:52]) - 1023 + 127;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  task automatic beat8(input logic [7:0] x, input logic [31:0] exp);
    @(negedge clk); v8 = 1; d8 = x;
    #1 chk("b8_in_ready", 32'(rdy8), 1);
    @(negedge clk); v8 = 0; chk("b8_lat1", 32'(ov8), 0);
    @(negedge clk); chk("b8_lat2", 32'(ov8), 0);
    @(negedge clk); chk("b8_lat3", 32'(ov8), 1);
    chk($sformatf("b8_%h", x), f8, exp);
  endtask

  task automatic beat32(input logic [31:0] x, input logic [31:0] eu, input logic [31:0] es);
    @(negedge clk); v32 = 1; d32 = x;
    @(negedge clk); v32 = 0;
    @(negedge clk);
    @(negedge clk);
    chk("b32_valid", {30'b0, ov_u, ov_s}, 3);
    chk($sformatf("b32u_%h", x), f_u, eu);
    chk($sformatf("b32s_%h", x), f_s, es);
  endtask

  initial begin
    logic [7:0] src [4];
    logic [31:0] ex [4];
    logic [31:0] e;
    logic [31:0] q [$];
    int idx, k, sent, got;
    bit pend;
    src = '{8'h01, 8'h02, 8'h04, 8'h08};
    ex = '{32'h3C000000, 32'h3C800000, 32'h3D000000, 32'h3D800000};
    #12;
    chk("rst_valid", 32'(ov8), 0);
    chk("rst_fp", f8, 0);
    @(negedge clk); rst_n = 1;
    #1 chk("rst_in_ready", 32'(rdy8), 1);

    beat8(8'h40, 32'h3F000000);
    beat8(8'h7F, 32'h3F7E0000);
    beat8(8'h01, 32'h3C000000);
    beat8(8'h80, 32'hBF800000);
    beat8(8'h00, 32'h00000000);
    beat8(8'hC0, 32'hBF000000);

    beat32(32'h01000001, 32'h4B800000, 32'h4B800000);
    beat32(32'h01000003, 32'h4B800002, 32'h4B800002);
    beat32(32'hFFFFFFFF, 32'h4F800000, 32'hBF800000);
    beat32(32'h80000000, 32'h4F000000, 32'hCF000000);

    idx = 0; k = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      or8 = c >= 6;
      v8 = idx < 4;
      if (idx < 4) d8 = src[idx];
      #1;
      if (c == 3) chk("bp_in_ready", 32'(rdy8), 0);
      if (c >= 3 && c < 6) begin
        chk("bp_hold_valid", 32'(ov8), 1);
        chk("bp_hold_fp", f8, 32'h3C000000);
      end
      if (ov8 && or8) begin
        e = (k < 4) ? ex[k] : 'x;
        chk("bp_out", f8, e);
        k++;
      end
      if (v8 && rdy8) idx++;
    end
    chk("bp_count", 32'(k), 4);

    sent = 0; got = 0; pend = 0;
    for (int c = 0; c < 6000 && got < 1000; c++) begin
      @(negedge clk);
      or8 = $urandom_range(0, 3) != 0;
      if (!pend && sent < 1000 && $urandom_range(0, 3) != 0) begin
        pend = 1;
        d8 = 8'($urandom);
      end
      v8 = pend;
      #1;
      if (ov8 && or8) begin
        e = (q.size() != 0) ? q.pop_front() : 'x;
        chk("rnd_out", f8, e);
        got++;
      end
      if (v8 && rdy8) begin
        q.push_back(ref8(d8));
        pend = 0;
        sent++;
      end
    end
    chk("rnd_count", 32'(got), 1000);
    @(negedge clk); v8 = 0; or8 = 1;
    repeat (4) @(negedge clk);

    or8 = 0; v8 = 1; d8 = 8'h10;
    @(negedge clk); d8 = 8'h20;
    @(negedge clk); v8 = 0;
    @(negedge clk);
    #1 chk("mid_pre_valid", 32'(ov8), 1);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_valid", 32'(ov8), 0);
    chk("mid_rst_fp", f8, 0);
    @(negedge clk); rst_n = 1; or8 = 1;
    repeat (4) begin
      @(negedge clk);
      chk("mid_no_stale", 32'(ov8), 0);
    end
    beat8(8'h40, 32'h3F000000);

    $display("== %0d vectors applied, %0d miscompares ==", n, err);
    $finish;
  end
endmodule

// File: doc/fxp2float_pipe.md
Name: fxp2float_pipe

Overview:
Parametrised, pipelined converter from a signed or unsigned fixed-point word (WOI integer bits, WOF fraction bits) to IEEE-754 binary32. It generalises our 8-bit Q1.7 combinational converter in four ways:
- any input width up to 32 bits;
- correct handling of the most-negative input;
- round-to-nearest-even when the input has more than 24 significant bits;
- a valid/ready streaming interface with backpressure.

It sits between the fixed-point datapath (encoder/decoder MAC outputs) and the float32 output/compare logic.

Parameters:
WOI, 1, integer bits, including the sign bit when SIGNED=1.
WOF, 7, fraction bits. W = WOI+WOF; required 2 <= W <= 32 and 0 <= WOF <= 126.
SIGNED, 1, 1 = two's-complement input; 0 = unsigned input.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  in_fxp holds a valid beat.
in_ready  output  1  block accepts a beat this cycle.
in_fxp  input  W  fixed-point value = in_fxp * 2^-WOF.
out_valid  output  1  out_fp32 holds a valid result.
out_ready  input  1  downstream accepts the result this cycle.
out_fp32  output  32  binary32 result {s, e[7:0], m[22:0]}.

Behaviour:
- Reset: one clock, asynchronous active-low reset. While rst_n=0, all stage valid flags and out_valid = 0 and out_fp32 = 32'h0. in_ready = 1 once rst_n is high. Reset asserted mid-stream discards all in-flight beats; there is no partial output.
- Handshake:
  - A beat transfers on the input when in_valid & in_ready, and on the output when out_valid & out_ready.
  - in_valid and out_valid must hold, with stable data, until accepted.
  - out_fp32 is stable while out_valid=1 and out_ready=0.
- Pipeline: 3 register stages (S1, S2, S3); S3 drives the outputs. Latency is 3 cycles from input acceptance to out_valid. Throughput is 1 beat/cycle while out_ready=1.
- Stall rule:
  - stage k loads when it is empty or stage k+1 loads/drains;
  - in_ready = ~S1_valid | S1 advancing (combinational chain from out_ready allowed);
  - no bubbles are inserted.
- Capacity: up to 3 beats held while out_ready=0. Input order is preserved.
- S1 (sign/magnitude):
  - s = SIGNED ? in_fxp[W-1] : 0;
  - mag = s ? -in_fxp : in_fxp, computed W bits wide as unsigned. The most-negative input -2^(W-1) gives mag = 2^(W-1), correctly.
  - zero flag = (in_fxp == 0).
- S2 (normalise):
  - p = index of the leading one of mag, 0..W-1, over all W bits;
  - shift mag left so the leading one sits at bit 31 of a 32-bit field;
  - e_pre = p - WOF + 127, computed 9 bits wide.
- S3 (round/pack):
  - mantissa = the 23 bits below the leading one;
  - guard = next bit, sticky = OR of the remaining bits; rounding is only possible when p > 23;
  - round up when guard & (sticky | mantissa LSB);
  - mantissa overflow on round-up gives m = 0 and e = e_pre + 1.
- Zero: input 0 gives 32'h00000000 (+0.0), never -0.0.
- Range: the parameter constraints guarantee 1 <= e <= 254, so no denormals, infinities or NaNs are ever produced.
- Unsigned mode: SIGNED=0 gives s = 0 always, and bit W-1 is magnitude.

Test Plan:
- WOI=1, WOF=7, SIGNED=1, single beats, out_ready=1:
  - 8'h40 -> 32'h3F000000;
  - 8'h7F -> 32'h3F7E0000;
  - 8'h01 -> 32'h3C000000;
  - 8'h80 -> 32'hBF800000 (most-negative);
  - 8'h00 -> 32'h00000000;
  - 8'hC0 -> 32'hBF000000;
  - out_valid exactly 3 cycles after acceptance in every case.
- WOI=32, WOF=0, SIGNED=0, rounding:
  - 32'h01000001 -> 32'h4B800000 (tie to even, down);
  - 32'h01000003 -> 32'h4B800002 (tie, up);
  - 32'hFFFFFFFF -> 32'h4F800000 (carry into exponent).
- WOI=32, WOF=0, SIGNED=1:
  - 32'h80000000 -> 32'hCF000000;
  - 32'hFFFFFFFF -> 32'hBF800000.
- Backpressure: stream 8'h01, 8'h02, 8'h04, 8'h08 back-to-back with out_ready=0 for 6 cycles.
  - in_ready must drop after 3 beats are held.
  - Outputs 3C000000, 3C800000, 3D000000, 3D800000 appear in order with no loss or duplication.
  - out_fp32 stays stable while stalled.
- Full throughput: random 1000-beat stream with random in_valid/out_ready against a float reference model; all results must match bit-exactly.
- Reset mid-stream: assert rst_n=0 with 2 beats in flight.
  - out_valid=0 and out_fp32=0 immediately (asynchronous).
  - After release, there is no stale output, and a new beat 8'h40 yields 3F000000 after 3 cycles.
